// File: rtl/lsu_queue_pkg.sv
// Shared types and helpers for the queued load/store unit.
package lsu_queue_pkg;

  // Memory operation encodings as presented by the load/store buffer.
  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  // Transfer size encodings for the memory controller.
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // True for every operation that reads memory.
  function automatic logic is_load(input op_e op);
    logic load;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: load = 1'b1;
      default:                             load = 1'b0;
    endcase
    return load;
  endfunction

  // Transfer size implied by an operation.
  function automatic logic [1:0] op_size(input op_e op);
    logic [1:0] size;
    case (op)
      OP_LB, OP_LBU, OP_SB: size = MEM_SIZE_B;
      OP_LH, OP_LHU, OP_SH: size = MEM_SIZE_H;
      default:              size = MEM_SIZE_W;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_queue_fifo.sv
// Circular request buffer with per-entry kill bits and a bulk "kill all loads" strobe.
// The head kill flag already reflects a kill strobe arriving in the same cycle so the
// consumer can skip a freshly killed head without waiting a cycle.
module lsu_queue_fifo
  import lsu_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  op_e                    push_op,
  input  logic [ADDR_W-1:0]      push_addr,
  input  logic [DATA_W-1:0]      push_data,
  input  logic [TAG_W-1:0]       push_tag,
  input  logic                   pop,
  input  logic                   kill_loads,
  output logic                   head_valid,
  output op_e                    head_op,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [DATA_W-1:0]      head_data,
  output logic [TAG_W-1:0]       head_tag,
  output logic                   head_kill,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  op_e               op_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic              kill_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Payload storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= push_op;
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
      tag_mem[wr_ptr]  <= push_tag;
    end
  end

  // Pointers, occupancy and kill bits; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        kill_mem[i] <= 1'b0;
      end
    end else begin
      if (kill_loads) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (is_load(op_mem[i])) begin
            kill_mem[i] <= 1'b1;
          end
        end
      end
      if (push) begin
        kill_mem[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign head_op    = op_mem[rd_ptr];
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign head_tag   = tag_mem[rd_ptr];
  assign head_kill  = kill_mem[rd_ptr] | (kill_loads & is_load(op_mem[rd_ptr]));

endmodule

// File: rtl/lsu_queue.sv
// Queued load/store unit: buffers tagged requests in order, issues them one at a
// time to the memory controller, extends load data and reports completions.
// On rollback, queued loads are killed and an in-flight load finishes silently;
// stores are already committed and always complete.
module lsu_queue
  import lsu_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   req_valid_in,
  output logic                   req_ready_out,
  input  op_e                    req_op_in,
  input  logic [ADDR_W-1:0]      req_addr_in,
  input  logic [DATA_W-1:0]      req_data_in,
  input  logic [TAG_W-1:0]       req_tag_in,
  output logic                   mem_enable_out,
  output logic                   mem_rw_out,
  output logic [ADDR_W-1:0]      mem_addr_out,
  output logic [1:0]             mem_size_out,
  output logic [DATA_W-1:0]      mem_data_out,
  input  logic                   mem_end_in,
  input  logic [DATA_W-1:0]      mem_data_in,
  output logic                   cdb_valid_out,
  output logic [TAG_W-1:0]       cdb_tag_out,
  output logic [DATA_W-1:0]      cdb_data_out,
  output logic                   store_done_out,
  output logic [TAG_W-1:0]       store_tag_out,
  input  logic                   rollback_in,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  state_e            state;
  state_e            next_state;
  logic              push;
  logic              pop;
  logic              start_issue;
  logic              finish;
  logic              emit_load;
  logic              emit_store;
  logic              head_valid;
  op_e               head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [TAG_W-1:0]  head_tag;
  logic              head_kill;
  op_e               iss_op;
  logic [TAG_W-1:0]  iss_tag;
  logic [DATA_W-1:0] store_mask;
  logic [DATA_W-1:0] load_ext;

  // No bypass: a full queue refuses new work even when the head leaves this cycle.
  assign req_ready_out = (count_out < FULL_COUNT);
  assign push          = req_valid_in && req_ready_out && !rollback_in;

  lsu_queue_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_fifo (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .push       (push),
    .push_op    (req_op_in),
    .push_addr  (req_addr_in),
    .push_data  (req_data_in),
    .push_tag   (req_tag_in),
    .pop        (pop),
    .kill_loads (rollback_in),
    .head_valid (head_valid),
    .head_op    (head_op),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .head_tag   (head_tag),
    .head_kill  (head_kill),
    .count      (count_out)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle control: pop/issue in IDLE, completion handling otherwise.
  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    start_issue = 1'b0;
    finish      = 1'b0;
    emit_load   = 1'b0;
    emit_store  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (head_valid) begin
          pop = 1'b1;
          if (!head_kill) begin
            start_issue = 1'b1;
            next_state  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (mem_end_in) begin
          finish     = 1'b1;
          next_state = ST_IDLE;
          if (is_load(iss_op)) begin
            emit_load = !rollback_in;
          end else begin
            emit_store = 1'b1;
          end
        end else if (rollback_in && is_load(iss_op)) begin
          next_state = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (mem_end_in) begin
          finish     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Store data trimmed to the transfer size with the upper bits cleared; loads drive zero.
  always_comb begin
    store_mask = '0;
    case (head_op)
      OP_SB:   store_mask[7:0]  = head_data[7:0];
      OP_SH:   store_mask[15:0] = head_data[15:0];
      OP_SW:   store_mask[31:0] = head_data[31:0];
      default: store_mask       = '0;
    endcase
  end

  // Sign or zero extension of returned load data according to the in-flight opcode.
  always_comb begin
    load_ext = '0;
    case (iss_op)
      OP_LB: begin
        load_ext       = {DATA_W{mem_data_in[7]}};
        load_ext[7:0]  = mem_data_in[7:0];
      end
      OP_LBU: begin
        load_ext[7:0]  = mem_data_in[7:0];
      end
      OP_LH: begin
        load_ext       = {DATA_W{mem_data_in[15]}};
        load_ext[15:0] = mem_data_in[15:0];
      end
      OP_LHU: begin
        load_ext[15:0] = mem_data_in[15:0];
      end
      default: begin
        load_ext[31:0] = mem_data_in[31:0];
      end
    endcase
  end

  // Issue registers: captured at issue and held steady until the controller signals completion.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_enable_out <= 1'b0;
      mem_rw_out     <= 1'b0;
      mem_addr_out   <= '0;
      mem_size_out   <= MEM_SIZE_B;
      mem_data_out   <= '0;
      iss_op         <= OP_LB;
      iss_tag        <= '0;
    end else if (start_issue) begin
      mem_enable_out <= 1'b1;
      mem_rw_out     <= is_load(head_op);
      mem_addr_out   <= head_addr;
      mem_size_out   <= op_size(head_op);
      mem_data_out   <= store_mask;
      iss_op         <= head_op;
      iss_tag        <= head_tag;
    end else if (finish) begin
      mem_enable_out <= 1'b0;
    end
  end

  // Result broadcast: one-cycle pulses on the CDB for loads and on store_done for stores.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid_out  <= 1'b0;
      cdb_tag_out    <= '0;
      cdb_data_out   <= '0;
      store_done_out <= 1'b0;
      store_tag_out  <= '0;
    end else begin
      cdb_valid_out  <= emit_load;
      store_done_out <= emit_store;
      if (emit_load) begin
        cdb_tag_out  <= iss_tag;
        cdb_data_out <= load_ext;
      end
      if (emit_store) begin
        store_tag_out <= iss_tag;
      end
    end
  end

endmodule

// File: tb/tb_lsu_queue.sv
// Scoreboard bench for lsu_queue: directed scenarios followed by randomized traffic,
// all checked against a queue-level reference model.
module tb_lsu_queue;
  import lsu_queue_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic              req_valid_in = 1'b0;
  logic              req_ready_out;
  op_e               req_op_in = OP_LB;
  logic [ADDR_W-1:0] req_addr_in = '0;
  logic [DATA_W-1:0] req_data_in = '0;
  logic [TAG_W-1:0]  req_tag_in = '0;
  logic              mem_enable_out;
  logic              mem_rw_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [1:0]        mem_size_out;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_end_in = 1'b0;
  logic [DATA_W-1:0] mem_data_in = '0;
  logic              cdb_valid_out;
  logic [TAG_W-1:0]  cdb_tag_out;
  logic [DATA_W-1:0] cdb_data_out;
  logic              store_done_out;
  logic [TAG_W-1:0]  store_tag_out;
  logic              rollback_in = 1'b0;
  logic [$clog2(DEPTH):0] count_out;

  lsu_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_op_in      (req_op_in),
    .req_addr_in    (req_addr_in),
    .req_data_in    (req_data_in),
    .req_tag_in     (req_tag_in),
    .mem_enable_out (mem_enable_out),
    .mem_rw_out     (mem_rw_out),
    .mem_addr_out   (mem_addr_out),
    .mem_size_out   (mem_size_out),
    .mem_data_out   (mem_data_out),
    .mem_end_in     (mem_end_in),
    .mem_data_in    (mem_data_in),
    .cdb_valid_out  (cdb_valid_out),
    .cdb_tag_out    (cdb_tag_out),
    .cdb_data_out   (cdb_data_out),
    .store_done_out (store_done_out),
    .store_tag_out  (store_tag_out),
    .rollback_in    (rollback_in),
    .count_out      (count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
    bit          killed;
  } req_t;

  typedef struct {
    bit          is_ld;
    logic [3:0]  tag;
    logic [31:0] data;
  } res_t;

  req_t model_q[$];
  res_t res_q[$];
  req_t fl_req;
  bit   fl_valid = 1'b0;
  bit   fl_discard = 1'b0;
  bit   end_pending = 1'b0;
  bit   prev_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic bit ref_is_load(input op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic [1:0] ref_size(input op_e op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] ref_load(input op_e op, input logic [31:0] d);
    longint v;
    case (op)
      OP_LB:   begin v = longint'(d % 256);   if (v >= 128)   v = v - 256;   end
      OP_LBU:  begin v = longint'(d % 256);   end
      OP_LH:   begin v = longint'(d % 65536); if (v >= 32768) v = v - 65536; end
      OP_LHU:  begin v = longint'(d % 65536); end
      default: begin v = longint'(d);         end
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input op_e op, input logic [31:0] d);
    if (op == OP_SB) return d % 256;
    if (op == OP_SH) return d % 65536;
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Drive one cycle of inputs at the falling edge, update the model with what the
  // following rising edge does, and return 2ns after that edge with pulses cleared.
  task automatic applyStimulus(input bit v, input op_e op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] tag,
                               input bit rb, input bit me, input logic [31:0] md);
    bit   accept;
    req_t r;
    res_t e;
    @(negedge clk_in);
    req_valid_in = v;
    req_op_in    = op;
    req_addr_in  = addr;
    req_data_in  = data;
    req_tag_in   = tag;
    rollback_in  = rb;
    mem_end_in   = me;
    mem_data_in  = md;
    accept = v && req_ready_out && !rb;
    if (rb) begin
      foreach (model_q[i]) begin
        if (ref_is_load(model_q[i].op)) model_q[i].killed = 1'b1;
      end
      if (fl_valid && ref_is_load(fl_req.op)) fl_discard = 1'b1;
    end
    if (me && fl_valid) begin
      if (!fl_discard) begin
        e.is_ld = ref_is_load(fl_req.op);
        e.tag   = fl_req.tag;
        e.data  = e.is_ld ? ref_load(fl_req.op, md) : 32'h0;
        res_q.push_back(e);
      end
      fl_valid    = 1'b0;
      end_pending = 1'b1;
    end
    if (accept) begin
      r.op = op; r.addr = addr; r.data = data; r.tag = tag; r.killed = 1'b0;
      model_q.push_back(r);
    end
    @(posedge clk_in);
    #2;
    req_valid_in = 1'b0;
    rollback_in  = 1'b0;
    mem_end_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, OP_LB, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic pushReq(input op_e op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] tag);
    applyStimulus(1'b1, op, addr, data, tag, 1'b0, 1'b0, '0);
  endtask

  task automatic waitIssue(input string name);
    for (int i = 0; i < 20 && !fl_valid; i++) idle(1);
    if (!fl_valid) reportFail({name, "_issue_timeout"});
  endtask

  task automatic completeTxn(input string name, input logic [31:0] md);
    waitIssue(name);
    if (fl_valid) applyStimulus(1'b0, OP_LB, '0, '0, '0, 1'b0, 1'b1, md);
  endtask

  // Monitor: checks every memory issue and every result pulse against the model.
  initial begin : monitor
    req_t r;
    res_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_n_in) begin
        prev_en     = 1'b0;
        end_pending = 1'b0;
        continue;
      end
      if (end_pending) begin
        checkOutput("mem_enable_drop", mem_enable_out, 0);
        end_pending = 1'b0;
      end
      if (mem_enable_out && !prev_en) begin
        while (model_q.size() > 0 && model_q[0].killed) void'(model_q.pop_front());
        if (model_q.size() == 0) begin
          reportFail("unexpected_issue");
        end else begin
          r = model_q.pop_front();
          fl_req = r; fl_valid = 1'b1; fl_discard = 1'b0;
          checkOutput("issue_rw",   mem_rw_out,   ref_is_load(r.op));
          checkOutput("issue_addr", mem_addr_out, r.addr);
          checkOutput("issue_size", mem_size_out, ref_size(r.op));
          if (!ref_is_load(r.op)) checkOutput("issue_data", mem_data_out, ref_store(r.op, r.data));
        end
      end else if (mem_enable_out && fl_valid) begin
        checkOutput("mem_hold", {mem_rw_out, mem_size_out, mem_addr_out},
                    {ref_is_load(fl_req.op), ref_size(fl_req.op), fl_req.addr});
      end
      if (cdb_valid_out && store_done_out) reportFail("cdb_and_store_same_cycle");
      if (cdb_valid_out) begin
        if (res_q.size() == 0 || !res_q[0].is_ld) begin
          reportFail("unexpected_cdb");
        end else begin
          e = res_q.pop_front();
          checkOutput("cdb_tag",  cdb_tag_out,  e.tag);
          checkOutput("cdb_data", cdb_data_out, e.data);
        end
      end
      if (store_done_out) begin
        if (res_q.size() == 0 || res_q[0].is_ld) begin
          reportFail("unexpected_store_done");
        end else begin
          e = res_q.pop_front();
          checkOutput("store_tag", store_tag_out, e.tag);
        end
      end
      prev_en = mem_enable_out;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL global_timeout at %0t", $time);
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin : stimulus
    int live;
    logic [31:0] md;

    // Reset values
    #3;
    checkOutput("rst_mem_enable", mem_enable_out, 0);
    checkOutput("rst_cdb_valid",  cdb_valid_out,  0);
    checkOutput("rst_store_done", store_done_out, 0);
    checkOutput("rst_count",      count_out,      0);
    checkOutput("rst_ready",      req_ready_out,  1);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // LB with sign extension, latency and pulse width
    $display("[TB] directed: LB / LBU");
    pushReq(OP_LB, 32'h100, 32'h0, 4'd3);
    checkOutput("lat_count", count_out, 1);
    checkOutput("lat_enable_low", mem_enable_out, 0);
    idle(1);
    checkOutput("lat_enable_high", mem_enable_out, 1);
    idle(2);
    completeTxn("lb", 32'h000000F0);
    checkOutput("lb_cdb_valid", cdb_valid_out, 1);
    checkOutput("lb_cdb_tag",   cdb_tag_out,   3);
    checkOutput("lb_cdb_data",  cdb_data_out,  32'hFFFFFFF0);
    idle(1);
    checkOutput("lb_cdb_pulse", cdb_valid_out, 0);
    pushReq(OP_LBU, 32'h100, 32'h0, 4'd3);
    idle(3);
    completeTxn("lbu", 32'h000000F0);
    checkOutput("lbu_cdb_data", cdb_data_out, 32'h000000F0);

    // LW passes the full word
    $display("[TB] directed: LW");
    pushReq(OP_LW, 32'h104, 32'h0, 4'd1);
    completeTxn("lw", 32'h12348765);
    checkOutput("lw_cdb_data", cdb_data_out, 32'h12348765);

    // SH masks data and reports on store_done only
    $display("[TB] directed: SH");
    pushReq(OP_SH, 32'h204, 32'hDEADBEEF, 4'd5);
    waitIssue("sh");
    checkOutput("sh_rw",   mem_rw_out,   0);
    checkOutput("sh_size", mem_size_out, 1);
    checkOutput("sh_data", mem_data_out, 32'h0000BEEF);
    completeTxn("sh", 32'h0);
    checkOutput("sh_store_done", store_done_out, 1);
    checkOutput("sh_store_tag",  store_tag_out,  5);
    checkOutput("sh_no_cdb",     cdb_valid_out,  0);

    // Full queue behind a stalled transaction
    $display("[TB] directed: full queue");
    pushReq(OP_SW, 32'h400, 32'h11, 4'd9);
    pushReq(OP_LW,  32'h410, 32'h0,  4'd0);
    pushReq(OP_LBU, 32'h414, 32'h0,  4'd1);
    pushReq(OP_SB,  32'h418, 32'h77, 4'd2);
    pushReq(OP_LH,  32'h41C, 32'h0,  4'd3);
    checkOutput("full_count", count_out,     4);
    checkOutput("full_ready", req_ready_out, 0);
    pushReq(OP_LW, 32'h420, 32'h0, 4'd4);
    pushReq(OP_LW, 32'h420, 32'h0, 4'd4);
    checkOutput("full_count_hold", count_out, 4);
    for (int i = 0; i < 5; i++) completeTxn("full_drain", $urandom);
    idle(2);
    checkOutput("full_drained", count_out, 0);

    // Rollback with a load in flight and a store and load queued
    $display("[TB] directed: rollback");
    pushReq(OP_LW, 32'h500, 32'h0,        4'd2);
    pushReq(OP_SW, 32'h504, 32'hA5A5A5A5, 4'd6);
    pushReq(OP_LB, 32'h508, 32'h0,        4'd7);
    applyStimulus(1'b0, OP_LB, '0, '0, '0, 1'b1, 1'b0, '0);
    checkOutput("rb_no_abort", mem_enable_out, 1);
    checkOutput("rb_count",    count_out,      2);
    idle(1);
    completeTxn("rb_lw", 32'h00000080);
    checkOutput("rb_lw_no_cdb", cdb_valid_out, 0);
    completeTxn("rb_sw", 32'h0);
    checkOutput("rb_store_done", store_done_out, 1);
    checkOutput("rb_store_tag",  store_tag_out,  6);
    idle(3);
    checkOutput("rb_count_empty", count_out, 0);

    // Asynchronous reset in the middle of a transaction
    $display("[TB] directed: mid-transaction reset");
    pushReq(OP_LW, 32'h600, 32'h0, 4'd8);
    pushReq(OP_LW, 32'h604, 32'h0, 4'd9);
    idle(1);
    #1;
    rst_n_in = 1'b0;
    #1;
    checkOutput("arst_mem_enable", mem_enable_out, 0);
    checkOutput("arst_cdb_valid",  cdb_valid_out,  0);
    checkOutput("arst_count",      count_out,      0);
    model_q.delete();
    res_q.delete();
    fl_valid    = 1'b0;
    fl_discard  = 1'b0;
    end_pending = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    pushReq(OP_LW, 32'h300, 32'h0, 4'd10);
    completeTxn("post_reset_lw", 32'hCAFEF00D);
    checkOutput("post_reset_cdb_data", cdb_data_out, 32'hCAFEF00D);
    idle(2);

    // Randomized traffic with rollbacks and stray completion pulses
    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      md = $urandom;
      applyStimulus(($urandom % 3) != 0, op_e'($urandom_range(0, 7)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), ($urandom % 25) == 0,
                    fl_valid ? (($urandom % 3) == 0) : (($urandom % 12) == 0), md);
    end

    // Drain
    for (int i = 0; i < 200; i++) begin
      live = 0;
      foreach (model_q[j]) if (!model_q[j].killed) live++;
      if (live == 0 && !fl_valid) break;
      applyStimulus(1'b0, OP_LB, '0, '0, '0, 1'b0, fl_valid && (($urandom % 2) == 0), $urandom);
    end
    idle(DEPTH + 2);
    live = 0;
    foreach (model_q[j]) if (!model_q[j].killed) live++;
    checkOutput("final_live_pending", live, 0);
    checkOutput("final_results_pending", res_q.size(), 0);
    checkOutput("final_count", count_out, 0);
    checkOutput("final_enable", mem_enable_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
